// File: rtl/ped_request_unit.sv
// ped_request_unit
//   Front end of the intersection traffic controller for the two pedestrian
//   push-buttons. Each button goes through its own channel: a two-flop
//   synchroniser, a tick-based debouncer, a request FSM that latches a
//   crossing request until the controller acknowledges it, a post-service
//   cooldown that drops new presses, and a stuck-button fault detector.
//   Channel 0 is vertical, channel 1 is horizontal; they never interact.
//
// Ports
//   clk, rst_n       system clock, asynchronous active-low reset
//   tick_in          time-base strobe; all tick counters advance only on it
//   btn_v, btn_h     raw asynchronous buttons, active-high
//   ack_v, ack_h     one-cycle "request served" pulses from the controller
//   req_v, req_h     latched crossing requests (registered)
//   fault_v, fault_h stuck-button indications (registered)
module ped_request_unit #(
  parameter int unsigned DEBOUNCE_TICKS = 4,
  parameter int unsigned COOLDOWN_TICKS = 20,
  parameter int unsigned STUCK_TICKS    = 100,
  parameter int unsigned CNT_W          = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick_in,
  input  logic btn_v,
  input  logic btn_h,
  input  logic ack_v,
  input  logic ack_h,
  output logic req_v,
  output logic req_h,
  output logic fault_v,
  output logic fault_h
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_COOLDOWN,
    ST_STUCK
  } state_e;

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_TICKS - 1);
  localparam logic [CNT_W-1:0] COOL_LAST = CNT_W'(COOLDOWN_TICKS - 1);
  localparam logic [CNT_W-1:0] STUCK_LIM = CNT_W'(STUCK_TICKS);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [1:0] btn;
  logic [1:0] ack;
  logic [1:0] req;
  logic [1:0] fault;

  assign btn = {btn_h, btn_v};
  assign ack = {ack_h, ack_v};

  for (genvar ch = 0; ch < 2; ch++) begin : g_ch
    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             deb_q, deb_d;
    logic             deb_prev_q, deb_prev_d;
    logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
    logic [CNT_W-1:0] stuck_cnt_q, stuck_cnt_d;
    logic [CNT_W-1:0] cool_cnt_q, cool_cnt_d;
    state_e           state_q, state_d;
    logic             req_q, req_d;
    logic             fault_q, fault_d;
    logic             press;
    logic             stuck_hit;

    always_comb begin
      sync1_d     = btn[ch];
      sync2_d     = sync1_q;
      deb_d       = deb_q;
      deb_cnt_d   = deb_cnt_q;
      deb_prev_d  = deb_q;
      stuck_cnt_d = stuck_cnt_q;
      cool_cnt_d  = cool_cnt_q;
      state_d     = state_q;

      // Debounce: any agreeing cycle restarts the count, so only an
      // uninterrupted run of DEBOUNCE_TICKS disagreeing ticks flips the level.
      if (sync2_q == deb_q) begin
        deb_cnt_d = '0;
      end else if (tick_in) begin
        if (deb_cnt_q == DEB_LAST) begin
          deb_d     = ~deb_q;
          deb_cnt_d = '0;
        end else begin
          deb_cnt_d = deb_cnt_q + CNT_ONE;
        end
      end

      // Press pulses on the cycle after the debounced level rises.
      press = deb_q & ~deb_prev_q;

      if (!deb_q) begin
        stuck_cnt_d = '0;
      end else if (tick_in && (stuck_cnt_q != STUCK_LIM)) begin
        stuck_cnt_d = stuck_cnt_q + CNT_ONE;
      end

      // The counter saturates, so this stays true for as long as the
      // button remains debounced-high after the threshold.
      stuck_hit = deb_q && (stuck_cnt_q == STUCK_LIM);

      unique case (state_q)
        ST_IDLE: begin
          if (stuck_hit)  state_d = ST_STUCK;
          else if (press) state_d = ST_REQ;
        end
        ST_REQ: begin
          if (stuck_hit) begin
            state_d = ST_STUCK;
          end else if (ack[ch]) begin
            state_d    = ST_COOLDOWN;
            cool_cnt_d = '0;
          end
        end
        ST_COOLDOWN: begin
          if (stuck_hit) begin
            state_d = ST_STUCK;
          end else if (tick_in) begin
            if (cool_cnt_q == COOL_LAST) begin
              state_d    = ST_IDLE;
              cool_cnt_d = '0;
            end else begin
              cool_cnt_d = cool_cnt_q + CNT_ONE;
            end
          end
        end
        ST_STUCK: begin
          if (!deb_q) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase

      req_d   = (state_d == ST_REQ);
      fault_d = (state_d == ST_STUCK);
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync1_q     <= 1'b0;
        sync2_q     <= 1'b0;
        deb_q       <= 1'b0;
        deb_prev_q  <= 1'b0;
        deb_cnt_q   <= '0;
        stuck_cnt_q <= '0;
        cool_cnt_q  <= '0;
        state_q     <= ST_IDLE;
        req_q       <= 1'b0;
        fault_q     <= 1'b0;
      end else begin
        sync1_q     <= sync1_d;
        sync2_q     <= sync2_d;
        deb_q       <= deb_d;
        deb_prev_q  <= deb_prev_d;
        deb_cnt_q   <= deb_cnt_d;
        stuck_cnt_q <= stuck_cnt_d;
        cool_cnt_q  <= cool_cnt_d;
        state_q     <= state_d;
        req_q       <= req_d;
        fault_q     <= fault_d;
      end
    end

    assign req[ch]   = req_q;
    assign fault[ch] = fault_q;
  end

  assign req_v   = req[0];
  assign req_h   = req[1];
  assign fault_v = fault[0];
  assign fault_h = fault[1];

endmodule

// File: tb/tb_ped_request_unit.sv
// Directed bench for ped_request_unit with default parameters
// (debounce 4, cooldown 20, stuck 100). Inputs change 1 time unit after a
// rising edge; outputs are checked at the same point.
module tb_ped_request_unit;

  logic clk = 1'b0;
  logic rst_n;
  logic tick_in;
  logic btn_v, btn_h, ack_v, ack_h;
  logic req_v, req_h, fault_v, fault_h;

  int checks   = 0;
  int failures = 0;

  ped_request_unit #(
    .DEBOUNCE_TICKS(4),
    .COOLDOWN_TICKS(20),
    .STUCK_TICKS   (100),
    .CNT_W         (8)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .tick_in(tick_in),
    .btn_v  (btn_v),
    .btn_h  (btn_h),
    .ack_v  (ack_v),
    .ack_h  (ack_h),
    .req_v  (req_v),
    .req_h  (req_h),
    .fault_v(fault_v),
    .fault_h(fault_h)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] exp);
    check({tag, ".req_v"},   req_v,   exp[3]);
    check({tag, ".req_h"},   req_h,   exp[2]);
    check({tag, ".fault_v"}, fault_v, exp[1]);
    check({tag, ".fault_h"}, fault_h, exp[0]);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; tick_in = 1'b1;
    btn_v = 1'b0; btn_h = 1'b0; ack_v = 1'b0; ack_h = 1'b0;
    cyc(2);
    check_all("reset", 4'b0000);
    rst_n = 1'b1;
    cyc(2);
    check_all("post_reset", 4'b0000);

    // Glitches of 2 and 3 synchronised cycles never reach the debounce length.
    btn_v = 1'b1; cyc(2); btn_v = 1'b0;
    for (int i = 0; i < 12; i++) begin
      cyc(1);
      check("glitch2.req_v", req_v, 1'b0);
    end
    btn_v = 1'b1; cyc(3); btn_v = 1'b0;
    for (int i = 0; i < 12; i++) begin
      cyc(1);
      check("glitch3.req_v", req_v, 1'b0);
    end

    // Held press: request appears exactly 7 cycles after the button rises.
    btn_v = 1'b1;
    cyc(6);
    check("press.req_v_e6", req_v, 1'b0);
    cyc(1);
    check("press.req_v_e7", req_v, 1'b1);
    check("press.req_h_e7", req_h, 1'b0);
    cyc(3);
    check("press.req_v_e10", req_v, 1'b1);

    // Ack clears the request; a press 5 ticks later is dropped,
    // a press 25 ticks after ack is accepted.
    btn_v = 1'b0; ack_v = 1'b1;
    cyc(1);
    ack_v = 1'b0;
    check("ack.req_v", req_v, 1'b0);
    cyc(4);
    btn_v = 1'b1;
    cyc(8);
    check("cool_drop.req_v_a12", req_v, 1'b0);
    btn_v = 1'b0;
    cyc(13);
    check("cool_drop.req_v_a25", req_v, 1'b0);
    btn_v = 1'b1;
    cyc(6);
    check("after_cool.req_v_a31", req_v, 1'b0);
    cyc(1);
    check("after_cool.req_v_a32", req_v, 1'b1);
    btn_v = 1'b0; ack_v = 1'b1;
    cyc(1);
    ack_v = 1'b0;
    check("ack2.req_v", req_v, 1'b0);
    cyc(30);

    // A pulse of exactly the debounce length is accepted.
    btn_v = 1'b1; cyc(4); btn_v = 1'b0;
    cyc(2);
    check("pulse4.req_v_e6", req_v, 1'b0);
    cyc(1);
    check("pulse4.req_v_e7", req_v, 1'b1);
    cyc(5);

    // tick_in held low: ack still works, debounce and cooldown freeze.
    tick_in = 1'b0; ack_v = 1'b1;
    cyc(1);
    ack_v = 1'b0;
    check("notick.ack_req_v", req_v, 1'b0);
    btn_h = 1'b1;
    cyc(25);
    check("notick.req_h", req_h, 1'b0);
    btn_h = 1'b0;
    cyc(3);
    tick_in = 1'b1;
    btn_v = 1'b1;
    cyc(8);
    check("notick.cool_frozen_req_v", req_v, 1'b0);
    btn_v = 1'b0;
    cyc(30);
    check_all("notick.settled", 4'b0000);

    // Stuck horizontal button.
    btn_h = 1'b1;
    cyc(7);
    check("stuck.req_h_e7", req_h, 1'b1);
    cyc(99);
    check("stuck.req_h_e106", req_h, 1'b1);
    check("stuck.fault_h_e106", fault_h, 1'b0);
    cyc(1);
    check("stuck.fault_h_e107", fault_h, 1'b1);
    check("stuck.req_h_e107", req_h, 1'b0);
    check("stuck.fault_v_e107", fault_v, 1'b0);
    cyc(13);
    check("stuck.fault_h_e120", fault_h, 1'b1);
    btn_h = 1'b0;
    cyc(6);
    check("release.fault_h_r6", fault_h, 1'b1);
    cyc(1);
    check("release.fault_h_r7", fault_h, 1'b0);
    check("release.req_h_r7", req_h, 1'b0);
    cyc(10);
    check_all("release.settled", 4'b0000);

    // Both channels together; simultaneous acks; both then drop presses.
    btn_v = 1'b1; btn_h = 1'b1;
    cyc(6);
    check_all("both.e6", 4'b0000);
    cyc(1);
    check_all("both.e7", 4'b1100);
    btn_v = 1'b0; btn_h = 1'b0; ack_v = 1'b1; ack_h = 1'b1;
    cyc(1);
    ack_v = 1'b0; ack_h = 1'b0;
    check_all("both.ack", 4'b0000);
    cyc(6);
    btn_v = 1'b1; btn_h = 1'b1;
    cyc(7);
    check_all("both.cool_drop", 4'b0000);
    btn_v = 1'b0; btn_h = 1'b0;
    cyc(30);

    // Reset mid-operation: v requesting, h cooling down.
    btn_v = 1'b1; btn_h = 1'b1;
    cyc(7);
    check_all("rst_setup.e7", 4'b1100);
    btn_v = 1'b0; btn_h = 1'b0; ack_h = 1'b1;
    cyc(1);
    ack_h = 1'b0;
    check_all("rst_setup.h_acked", 4'b1000);
    cyc(1);
    rst_n = 1'b0;
    #1;
    check_all("midrst.async", 4'b0000);
    cyc(1);
    rst_n = 1'b1;
    cyc(1);
    check_all("midrst.released", 4'b0000);
    btn_h = 1'b1;
    cyc(6);
    check("midrst.req_h_e6", req_h, 1'b0);
    cyc(1);
    check("midrst.req_h_e7", req_h, 1'b1);
    check("midrst.req_v_e7", req_v, 1'b0);
    btn_h = 1'b0;
    cyc(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
